// File: rtl/spram_ctrl_if.sv
// Request, read-return and RAM-side signals of spram_ctrl.
// slave = the controller; master = requesters, rdata consumer and the RAM wrapper.
interface spram_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          wr_valid_in;
  logic [AW-1:0] wr_addr_in;
  logic [DW-1:0] wr_data_in;
  logic          wr_ready_out;
  logic          rd_valid_in;
  logic [AW-1:0] rd_addr_in;
  logic          rd_ready_out;
  logic          rdata_valid_out;
  logic [DW-1:0] rdata_out;
  logic          rdata_ready_in;
  logic [AW-1:0] ram_address_out;
  logic [DW-1:0] ram_data_out;
  logic          ram_wren_out;
  logic [DW-1:0] ram_q_in;

  modport slave (
    input  wr_valid_in, wr_addr_in, wr_data_in, rd_valid_in, rd_addr_in,
    input  rdata_ready_in, ram_q_in,
    output wr_ready_out, rd_ready_out, rdata_valid_out, rdata_out,
    output ram_address_out, ram_data_out, ram_wren_out
  );

  modport master (
    output wr_valid_in, wr_addr_in, wr_data_in, rd_valid_in, rd_addr_in,
    output rdata_ready_in, ram_q_in,
    input  wr_ready_out, rd_ready_out, rdata_valid_out, rdata_out,
    input  ram_address_out, ram_data_out, ram_wren_out
  );
endinterface

// File: rtl/spram_ctrl.sv
// spram_ctrl: merges a write and a read request stream onto a 1-cycle read-first single-port RAM.
// Latency read grant -> rdata_valid_out 2 cycles (3 with SPRAM_CTRL_OREG_EN defined).
// Reads issue only against a reserved return slot, so rdata backpressure stalls rd_ready_out via credits.

module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         full;
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign out_vld = (wr_ptr != rd_ptr);
  assign do_push = push_vld & ~full;
  assign do_pop  = pop_rdy & out_vld;
  assign out_dat = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
  end
endmodule

module spram_ctrl #(
  parameter int AW           = 10,
  parameter int DW           = 32,
`ifdef SPRAM_CTRL_OREG_EN
  parameter int OBUF_DEPTH   = 8,
`else
  parameter int OBUF_DEPTH   = 4,
`endif
  parameter int STARVE_LIMIT = 7
) (
  input  logic        clock_in,
  input  logic        reset_in,
  spram_ctrl_if.slave bus
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  logic [CW-1:0] credits_used;
  logic [7:0]    starve_cnt;
  logic          credit_ok;
  logic          force_rd;
  logic          rd_grant;
  logic          wr_grant;
  logic          pop;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          push_vld;
  logic [DW-1:0] push_dat;
  logic          obuf_vld;
  logic [DW-1:0] obuf_dat;

  assign credit_ok = credits_used < CW'(OBUF_DEPTH);
  assign force_rd  = (starve_cnt == 8'(STARVE_LIMIT));

  // Readies are forced low while reset is asserted so the reset values appear immediately.
  assign bus.rd_ready_out = ~reset_in & credit_ok & (~bus.wr_valid_in | force_rd);
  assign bus.wr_ready_out = ~reset_in & ~(bus.rd_valid_in & credit_ok & force_rd);
  assign rd_grant = bus.rd_valid_in & bus.rd_ready_out;
  assign wr_grant = bus.wr_valid_in & bus.wr_ready_out;
  assign pop      = obuf_vld & bus.rdata_ready_in;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      starve_cnt <= '0;
    end else if (rd_grant || !bus.rd_valid_in) begin
      starve_cnt <= '0;
    end else if (wr_grant && !force_rd) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      credits_used <= '0;
    end else begin
      case ({rd_grant, pop})
        2'b10:   credits_used <= credits_used + CW'(1);
        2'b01:   credits_used <= credits_used - CW'(1);
        default: credits_used <= credits_used;
      endcase
    end
  end

  always_comb begin
    bus.ram_address_out = addr_q;
    bus.ram_data_out    = data_q;
    bus.ram_wren_out    = 1'b0;
    if (wr_grant) begin
      bus.ram_address_out = bus.wr_addr_in;
      bus.ram_data_out    = bus.wr_data_in;
      bus.ram_wren_out    = 1'b1;
    end else if (rd_grant) begin
      bus.ram_address_out = bus.rd_addr_in;
    end
  end

  // Idle cycles keep the last address/data on the RAM port.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= bus.ram_address_out;
      data_q <= bus.ram_data_out;
    end
  end

`ifdef SPRAM_CTRL_OREG_EN
  logic [1:0]    rd_pipe;
  logic [DW-1:0] q_reg;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      rd_pipe <= '0;
      q_reg   <= '0;
    end else begin
      rd_pipe <= {rd_pipe[0], rd_grant};
      q_reg   <= bus.ram_q_in;
    end
  end

  assign push_vld = rd_pipe[1];
  assign push_dat = q_reg;
`else
  logic rd_pipe;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) rd_pipe <= 1'b0;
    else          rd_pipe <= rd_grant;
  end

  assign push_vld = rd_pipe;
  assign push_dat = bus.ram_q_in;
`endif

  sync_fifo #(
    .W     (DW),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk      (clock_in),
    .rst      (reset_in),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (pop),
    .out_vld  (obuf_vld),
    .out_dat  (obuf_dat)
  );

  assign bus.rdata_valid_out = obuf_vld;
  assign bus.rdata_out       = obuf_vld ? obuf_dat : '0;
endmodule

// File: tb/tb_spram_ctrl.sv
// Directed bench for spram_ctrl with a 1-cycle read-first RAM model and an in-order return scoreboard.
module tb_spram_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
`ifdef SPRAM_CTRL_OREG_EN
  localparam int OBUF = 8;
  localparam int LAT  = 3;
`else
  localparam int OBUF = 4;
  localparam int LAT  = 2;
`endif

  logic clock_in = 1'b0;
  logic reset_in;
  always #5 clock_in = ~clock_in;

  spram_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  spram_ctrl #(
    .AW           (AW),
    .DW           (DW),
    .OBUF_DEPTH   (OBUF),
    .STARVE_LIMIT (7)
  ) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_gnt_cnt = 0;
  int ret_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  logic [DW-1:0] exp_q [$];

  // Memories are stored XOR a per-address pattern so unwritten words read back distinct values.
  bit [DW-1:0] ram    [0:1023];
  bit [DW-1:0] shadow [0:1023];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(posedge clock_in) begin
    cyc <= cyc + 1;
    if (bus.ram_wren_out) ram[bus.ram_address_out] <= bus.ram_data_out ^ pat(bus.ram_address_out);
    bus.ram_q_in <= ram[bus.ram_address_out] ^ pat(bus.ram_address_out);
  end

  always @(negedge clock_in) begin
    if (reset_in) begin
      exp_q.delete();
    end else begin
      if (bus.rdata_valid_out && bus.rdata_ready_in) begin
        chk("ret_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("ret_dat", bus.rdata_out, exp_q.pop_front());
        if (ret_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        ret_cnt++;
      end
      if (bus.rd_valid_in && bus.rd_ready_out) begin
        exp_q.push_back(shadow[bus.rd_addr_in] ^ pat(bus.rd_addr_in));
        rd_gnt_cnt++;
      end
      if (bus.wr_valid_in && bus.wr_ready_out)
        shadow[bus.wr_addr_in] = bus.wr_data_in ^ pat(bus.wr_addr_in);
      if (dut.u_obuf.push_vld) chk("obuf_no_overflow", dut.u_obuf.full, 0);
    end
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in  = a;
    bus.wr_data_in  = d;
    @(negedge clock_in);
    chk("wr_ready", bus.wr_ready_out, 1);
    chk("wr_wren", bus.ram_wren_out, 1);
    chk("wr_addr", bus.ram_address_out, a);
    chk("wr_data", bus.ram_data_out, d);
    tick();
    bus.wr_valid_in = 1'b0;
  endtask

  task automatic read_one(input logic [AW-1:0] a, input logic [DW-1:0] expd);
    int n;
    n = 0;
    bus.rd_valid_in = 1'b1;
    bus.rd_addr_in  = a;
    @(negedge clock_in);
    chk("rd_ready", bus.rd_ready_out, 1);
    chk("rd_wren", bus.ram_wren_out, 0);
    chk("rd_addr", bus.ram_address_out, a);
    tick();
    bus.rd_valid_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock_in);
      if (bus.rdata_valid_out) begin
        n = i;
        break;
      end
      tick();
    end
    chk("rd_latency", n, LAT);
    chk("rd_data", bus.rdata_out, expd);
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [23:0] wv, rv;
    logic [9:0] nv;
    int g0, stale;

    reset_in            = 1'b1;
    bus.wr_valid_in     = 1'b1;
    bus.wr_addr_in      = 10'h3F;
    bus.wr_data_in      = 32'hFFFF_FFFF;
    bus.rd_valid_in     = 1'b1;
    bus.rd_addr_in      = '0;
    bus.rdata_ready_in  = 1'b1;
    #12;
    chk("rst_wr_ready", bus.wr_ready_out, 0);
    chk("rst_rd_ready", bus.rd_ready_out, 0);
    chk("rst_rdata_valid", bus.rdata_valid_out, 0);
    chk("rst_rdata", bus.rdata_out, 0);
    chk("rst_wren", bus.ram_wren_out, 0);
    chk("rst_addr", bus.ram_address_out, 0);
    chk("rst_data", bus.ram_data_out, 0);
    bus.wr_valid_in = 1'b0;
    bus.rd_valid_in = 1'b0;
    @(negedge clock_in);
    reset_in = 1'b0;
    tick();

    do_write(10'd3, 32'hA5A5_0001);
    read_one(10'd3, 32'hA5A5_0001);

    do_write(10'd5, 32'h0000_1234);
    read_one(10'd5, 32'h0000_1234);
    @(negedge clock_in);
    chk("idle_wren", bus.ram_wren_out, 0);
    chk("idle_addr_hold", bus.ram_address_out, 5);
    chk("idle_data_hold", bus.ram_data_out, 32'h0000_1234);
    tick();

    // Back-to-back reads of 0..15.
    ret_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      bus.rd_valid_in = 1'b1;
      bus.rd_addr_in  = AW'(k);
      @(negedge clock_in);
      chk("b2b_rd_ready", bus.rd_ready_out, 1);
      tick();
    end
    bus.rd_valid_in = 1'b0;
    repeat (LAT + 2) tick();
    chk("b2b_count", ret_cnt, 16);
    chk("b2b_no_gaps", last_cyc - first_cyc, 15);

    // Consumer stalled: only OBUF reads may be accepted.
    bus.rdata_ready_in = 1'b0;
    g0 = rd_gnt_cnt;
    a = 10'h20;
    bus.rd_valid_in = 1'b1;
    bus.rd_addr_in  = a;
    for (int k = 0; k < OBUF + 4; k++) begin
      @(negedge clock_in);
      if (bus.rd_ready_out) a = a + 10'd1;
      tick();
      bus.rd_addr_in = a;
    end
    chk("bp_grants", rd_gnt_cnt - g0, OBUF);
    @(negedge clock_in);
    chk("bp_stalled", bus.rd_ready_out, 0);
    tick();

    // No credit: writes win even once the starve counter saturates.
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in  = 10'h60;
    bus.wr_data_in  = 32'hDEAD_0000;
    nv = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock_in);
      nv[k] = bus.ram_wren_out;
      tick();
    end
    chk("nocredit_writes", nv, 10'h3FF);
    bus.rdata_ready_in = 1'b1;
    @(negedge clock_in);
    chk("pop_cycle_wr_ready", bus.wr_ready_out, 1);
    chk("pop_cycle_rd_ready", bus.rd_ready_out, 0);
    tick();
    @(negedge clock_in);
    chk("forced_rd_ready", bus.rd_ready_out, 1);
    chk("forced_wr_ready", bus.wr_ready_out, 0);
    tick();
    bus.wr_valid_in = 1'b0;
    bus.rd_valid_in = 1'b0;
    drain("bp_drained");
    @(negedge clock_in);
    chk("bp_restored", bus.rd_ready_out, 1);
    tick();

    // Both streams valid: 7 writes then 1 read, repeating.
    bus.wr_valid_in = 1'b1;
    bus.wr_addr_in  = 10'h40;
    bus.wr_data_in  = 32'h5A5A_0000;
    bus.rd_valid_in = 1'b1;
    bus.rd_addr_in  = 10'h41;
    wv = '0;
    rv = '0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clock_in);
      wv[k] = bus.ram_wren_out;
      rv[k] = bus.rd_valid_in & bus.rd_ready_out;
      tick();
    end
    chk("starve_wren", wv, 24'h7F7F7F);
    chk("starve_rd", rv, 24'h808080);
    bus.wr_valid_in = 1'b0;
    bus.rd_valid_in = 1'b0;
    drain("starve_drained");

    // Reset with reads in flight and data buffered.
    bus.rdata_ready_in = 1'b0;
    a = 10'h50;
    bus.rd_valid_in = 1'b1;
    bus.rd_addr_in  = a;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_in);
      tick();
      a = a + 10'd1;
      bus.rd_addr_in = a;
    end
    @(negedge clock_in);
    chk("pre_rst_valid", bus.rdata_valid_out, 1);
    #2;
    reset_in = 1'b1;
    #1;
    chk("arst_rdata_valid", bus.rdata_valid_out, 0);
    chk("arst_rdata", bus.rdata_out, 0);
    chk("arst_rd_ready", bus.rd_ready_out, 0);
    chk("arst_wr_ready", bus.wr_ready_out, 0);
    chk("arst_addr", bus.ram_address_out, 0);
    bus.rd_valid_in = 1'b0;
    @(negedge clock_in);
    #2;
    reset_in = 1'b0;
    bus.rdata_ready_in = 1'b1;
    tick();
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock_in);
      if (bus.rdata_valid_out) stale++;
      tick();
    end
    chk("rst_no_stale", stale, 0);
    bus.rdata_ready_in = 1'b0;
    g0 = rd_gnt_cnt;
    bus.rd_valid_in = 1'b1;
    bus.rd_addr_in  = 10'h70;
    repeat (OBUF + 3) tick();
    chk("rst_credits_full", rd_gnt_cnt - g0, OBUF);
    bus.rd_valid_in = 1'b0;
    bus.rdata_ready_in = 1'b1;
    drain("rst_drained");

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
